aes_key_sched_ctrl: RTL and testbench

AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

---
 rtl/aes_key_sched_ctrl_if.sv | 26 ++
 rtl/aes_key_sched_ctrl.sv | 104 ++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_sched_ctrl_if.sv
// rtl/aes_key_sched_ctrl_if.sv - key load, expansion-engine and round-key read signals
interface aes_key_sched_ctrl_if;
  logic         key_valid;
  logic [127:0] key_in;
  logic         key_ready;
  logic         exp_start;
  logic [127:0] exp_key;
  logic         exp_rkey_valid;
  logic [127:0] exp_rkey;
  logic         sched_done;
  logic         rd_en;
  logic [3:0]   rd_round;
  logic         rd_valid;
  logic [127:0] rd_key;
  logic         rd_err;

  modport slave (
    input  key_valid, key_in, exp_rkey_valid, exp_rkey, rd_en, rd_round,
    output key_ready, exp_start, exp_key, sched_done, rd_valid, rd_key, rd_err
  );

  modport master (
    output key_valid, key_in, exp_rkey_valid, exp_rkey, rd_en, rd_round,
    input  key_ready, exp_start, exp_key, sched_done, rd_valid, rd_key, rd_err
  );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - AES key-schedule controller with NR+1 round-key store
// Optional macro AES_KSC_ZEROIZE_EN clears the store whenever a new key is accepted.
module aes_key_sched_ctrl #(
  parameter int NR = 10
) (
  input logic                 CLK,
  input logic                 RST,
  aes_key_sched_ctrl_if.slave bus
);
  localparam int CW = $clog2(NR + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, COLLECT, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          key_ready_q, key_ready_d;
  logic [127:0]  exp_key_q, exp_key_d;
  logic [127:0]  store_q [NR+1];
  logic [127:0]  store_d [NR+1];
  logic          rd_valid_q, rd_valid_d;
  logic          rd_err_q, rd_err_d;
  logic [127:0]  rd_key_q, rd_key_d;
  logic          key_accept;
  logic          rd_ok;

  // key_ready is a flop so it stays low throughout reset and rises one cycle after release
  assign key_accept = bus.key_valid && key_ready_q;
  assign rd_ok      = bus.rd_en && (state_q == DONE) && (int'(bus.rd_round) <= NR);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    exp_key_d  = exp_key_q;
    store_d    = store_q;
    rd_valid_d = rd_ok;
    rd_err_d   = bus.rd_en && !rd_ok;
    rd_key_d   = rd_ok ? store_q[bus.rd_round] : '0;

    case (state_q)
      IDLE, DONE: begin
        if (key_accept) begin
          exp_key_d = bus.key_in;
          state_d   = LAUNCH;
`ifdef AES_KSC_ZEROIZE_EN
          for (int i = 0; i <= NR; i++) begin
            store_d[i] = '0;
          end
`endif
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = COLLECT;
      end
      COLLECT: begin
        if (bus.exp_rkey_valid) begin
          store_d[cnt_q] = bus.exp_rkey;
          if (cnt_q == CW'(NR)) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    key_ready_d = (state_d == IDLE) || (state_d == DONE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_ready_q <= 1'b0;
      exp_key_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      rd_key_q    <= '0;
      for (int i = 0; i <= NR; i++) begin
        store_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_ready_q <= key_ready_d;
      exp_key_q   <= exp_key_d;
      rd_valid_q  <= rd_valid_d;
      rd_err_q    <= rd_err_d;
      rd_key_q    <= rd_key_d;
      for (int i = 0; i <= NR; i++) begin
        store_q[i] <= store_d[i];
      end
    end
  end

  assign bus.key_ready  = key_ready_q;
  assign bus.exp_start  = (state_q == LAUNCH);
  assign bus.exp_key    = exp_key_q;
  assign bus.sched_done = (state_q == DONE);
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_err     = rd_err_q;
  assign bus.rd_key     = rd_key_q;
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - directed self-checking bench for aes_key_sched_ctrl
module tb_aes_key_sched_ctrl;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [127:0] rk [11];

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2 = 128'hfeedface_cafebabe_01234567_89abcdef;
  localparam logic [127:0] K3 = 128'h55555555_aaaaaaaa_33333333_cccccccc;

  aes_key_sched_ctrl_if bus ();

  aes_key_sched_ctrl #(.NR(10)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int r, input logic v, input logic e, input logic [127:0] k);
    bus.rd_en    = 1'b1;
    bus.rd_round = 4'(r);
    tick();
    bus.rd_en = 1'b0;
    chk($sformatf("rd_valid[%0d]", r), bus.rd_valid, v);
    chk($sformatf("rd_err[%0d]", r), bus.rd_err, e);
    chk($sformatf("rd_key[%0d]", r), bus.rd_key, k);
  endtask

  task automatic accept(input logic [127:0] k, input bit junk);
    bus.key_valid = 1'b1;
    bus.key_in    = k;
    tick();
    bus.key_valid = 1'b0;
    chk("exp_start_pulse", bus.exp_start, 1'b1);
    chk("exp_key_capture", bus.exp_key, k);
    chk("key_ready_launch", bus.key_ready, 1'b0);
    if (junk) begin
      bus.exp_rkey_valid = 1'b1;
      bus.exp_rkey       = '1;
    end
    tick();
    bus.exp_rkey_valid = 1'b0;
    chk("exp_start_low", bus.exp_start, 1'b0);
  endtask

  task automatic feed(input int n, input int gap_at, input int gap_len, input bit inv);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        bus.exp_rkey_valid = 1'b0;
        repeat (gap_len) tick();
      end
      bus.exp_rkey_valid = 1'b1;
      bus.exp_rkey       = inv ? ~rk[i] : rk[i];
      if (i == 10) chk("sched_done_before_last", bus.sched_done, 1'b0);
      tick();
    end
    bus.exp_rkey_valid = 1'b0;
    if (n == 11) chk("sched_done_after_last", bus.sched_done, 1'b1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.key_valid      = 1'b0;
    bus.key_in         = '0;
    bus.exp_rkey_valid = 1'b0;
    bus.exp_rkey       = '0;
    bus.rd_en          = 1'b0;
    bus.rd_round       = '0;
    rk[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    rk[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    rk[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
    rk[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
    rk[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
    rk[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
    rk[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
    rk[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
    rk[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
    rk[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
    rk[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    #12;
    chk("rst_key_ready", bus.key_ready, 1'b0);
    chk("rst_exp_start", bus.exp_start, 1'b0);
    chk("rst_sched_done", bus.sched_done, 1'b0);
    chk("rst_rd_valid", bus.rd_valid, 1'b0);
    chk("rst_rd_err", bus.rd_err, 1'b0);
    chk("rst_rd_key", bus.rd_key, '0);
    chk("rst_exp_key", bus.exp_key, '0);
    tick();
    rst = 1'b0;
    chk("key_ready_at_release", bus.key_ready, 1'b0);
    tick();
    chk("key_ready_after_release", bus.key_ready, 1'b1);
    rd(0, 1'b0, 1'b1, '0);

    // First load, with junk round key offered during LAUNCH
    accept(K1, 1'b1);
    feed(11, -1, 0, 1'b0);
    chk("key_ready_done", bus.key_ready, 1'b1);
    bus.rd_en = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      bus.rd_round = 4'(i);
      tick();
      chk($sformatf("b2b_valid[%0d]", i), bus.rd_valid, 1'b1);
      chk($sformatf("b2b_err[%0d]", i), bus.rd_err, 1'b0);
      chk($sformatf("b2b_key[%0d]", i), bus.rd_key, rk[i]);
    end
    bus.rd_round = 4'd11;
    tick();
    chk("rd11_err", bus.rd_err, 1'b1);
    chk("rd11_valid", bus.rd_valid, 1'b0);
    chk("rd11_key", bus.rd_key, '0);
    bus.rd_round = 4'd15;
    tick();
    chk("rd15_err", bus.rd_err, 1'b1);
    bus.rd_en = 1'b0;
    tick();
    chk("idle_rd_valid", bus.rd_valid, 1'b0);
    chk("idle_rd_err", bus.rd_err, 1'b0);
    chk("idle_rd_key", bus.rd_key, '0);
    bus.exp_rkey_valid = 1'b1;
    bus.exp_rkey       = '1;
    tick();
    bus.exp_rkey_valid = 1'b0;
    chk("done_ignores_rkey", bus.sched_done, 1'b1);
    rd(10, 1'b1, 1'b0, rk[10]);

    // Rekey in DONE with a simultaneous read of round 0
    bus.key_valid = 1'b1;
    bus.key_in    = K2;
    bus.rd_en     = 1'b1;
    bus.rd_round  = 4'd0;
    tick();
    bus.key_valid = 1'b0;
    bus.rd_en     = 1'b0;
    chk("rekey_rd_valid", bus.rd_valid, 1'b1);
    chk("rekey_rd_key_old", bus.rd_key, rk[0]);
    chk("rekey_sched_done", bus.sched_done, 1'b0);
    chk("rekey_exp_start", bus.exp_start, 1'b1);
    chk("rekey_exp_key", bus.exp_key, K2);
    tick();
    bus.key_valid = 1'b1;
    bus.key_in    = K3;
    bus.rd_en     = 1'b1;
    bus.rd_round  = 4'd3;
    tick();
    bus.key_valid = 1'b0;
    bus.rd_en     = 1'b0;
    chk("collect_rd_err", bus.rd_err, 1'b1);
    chk("collect_rd_valid", bus.rd_valid, 1'b0);
    chk("collect_rd_key", bus.rd_key, '0);
    chk("collect_key_ignored", bus.exp_key, K2);
    chk("collect_key_ready", bus.key_ready, 1'b0);
    feed(11, 5, 3, 1'b1);
    for (int i = 0; i <= 10; i++) begin
      rd(i, 1'b1, 1'b0, ~rk[i]);
    end

    // Reset after five round keys, then a full reload
    accept(K1, 1'b0);
    feed(5, -1, 0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_key_ready", bus.key_ready, 1'b0);
    chk("midrst_sched_done", bus.sched_done, 1'b0);
    chk("midrst_exp_start", bus.exp_start, 1'b0);
    chk("midrst_exp_key", bus.exp_key, '0);
    chk("midrst_rd_err", bus.rd_err, 1'b0);
    chk("midrst_rd_key", bus.rd_key, '0);
    #1;
    rst = 1'b0;
    tick();
    chk("postrst_key_ready", bus.key_ready, 1'b1);
    chk("postrst_sched_done", bus.sched_done, 1'b0);
    rd(0, 1'b0, 1'b1, '0);
    accept(K1, 1'b0);
    feed(11, -1, 0, 1'b0);
    rd(10, 1'b1, 1'b0, 128'h13111d7f_e3944a17_f307a78b_4d2b30c5);
    rd(4, 1'b1, 1'b0, rk[4]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
